pulse_sweep_sequencer: RTL
==========================

Name: pulse_sweep_sequencer

Overview:
Automates write-amplitude sweeps on the read/write/read pulse-train engine, replacing manual key presses. Each step loads a write DAC code and mode, fires one train trigger, waits for the engine's train-complete strobe, and idles a programmable gap. It then steps the code by a signed increment until the step count or a code limit is reached. It sits between the control/debounce front end and the pulse engine, and drives the engine's trigger, write-code and mode inputs.

Parameters:
CODE_W, 8, DAC code width; code 128 = 0 V, 0 = +5 V, 255 = -5 V
STEP_W, 6, width of step count and step index (max 63 steps)
CNT_W, 22, width of gap and timeout counters
GAP_CYCLES, 50_000, idle cycles between trains (1 ms at 50 MHz)
TIMEOUT_CYCLES, 2_000_000, maximum cycles to wait for eng_done before fault

Ports:
clk  in  1  system clock, 20 ns
reset_n  in  1  asynchronous active-low reset
start  in  1  level; a rising edge while idle launches a sweep
abort  in  1  level; highest priority, returns to IDLE
cfg_start_code  in  CODE_W  first write code
cfg_step  in  CODE_W  unsigned step magnitude
cfg_dir  in  1  0 = add step, 1 = subtract step
cfg_steps  in  STEP_W  number of trains in the sweep
cfg_mode  in  3  write-slot enable pattern forwarded to the engine
eng_done  in  1  one-cycle strobe from the engine when a train ends
eng_trig  out  1  one-cycle train trigger
eng_write_code  out  CODE_W  write level to the engine
eng_mode_sel  out  3  mode to the engine
step_idx  out  STEP_W  index of the current or last train
busy  out  1  high in every state except IDLE
sweep_done  out  1  one-cycle strobe on normal or saturated completion
sat  out  1  sticky; sweep ended early on code clamp; cleared at next start
fault  out  1  sticky; eng_done timeout; cleared at next start

Behaviour:
- Reset values: eng_trig=0, eng_write_code=128, eng_mode_sel=0, step_idx=0, busy=0, sweep_done=0, sat=0, fault=0, state=IDLE, start_q=0.
- States: IDLE, ARM, TRIG, WAIT_DONE, GAP, STEP.
- IDLE: eng_write_code=128 and eng_mode_sel=0.
  - On start=1 with start_q=0 in cycle T, the block latches all cfg_* inputs, clears sat, fault and step_idx, and goes to ARM.
  - Exception: if cfg_steps=0, it pulses sweep_done at T+1 and stays IDLE. No trigger is issued.
- ARM (1 cycle): drive eng_write_code=current code and eng_mode_sel=latched mode. The code is therefore stable one cycle before the trigger.
- TRIG (1 cycle): eng_trig=1, timeout counter cleared, go to WAIT_DONE. First trigger appears at T+2.
- WAIT_DONE:
  - On eng_done: go to GAP with the gap counter cleared.
  - When the timeout counter reaches TIMEOUT_CYCLES-1 with no eng_done: set fault and go to IDLE. No sweep_done is issued.
  - eng_done is ignored in every other state.
- GAP: count GAP_CYCLES cycles, then go to STEP.
- STEP (1 cycle):
  - If step_idx+1 == latched steps: pulse sweep_done and go to IDLE. step_idx holds the last index.
  - Otherwise compute next = code ± step in CODE_W+1 bits.
  - If next is outside 0..255: clamp code to 0 or 255, set sat, pulse sweep_done, go to IDLE.
  - Else: code=next, step_idx+1, go to ARM.
- abort=1 in any state: next state is IDLE, eng_trig is forced 0 in the same cycle, no sweep_done, sat and fault unchanged. An abort in the same cycle as a start edge wins.
- A start edge while busy is ignored. A held start does not retrigger; a new edge is required.
- eng_write_code and eng_mode_sel are registered, with no combinational path from inputs.
- Asserting reset mid-sweep returns every output to its reset value immediately.

Decomposition:
- Package pulse_pkg:
  - CODE_W
  - ZERO_CODE=128
  - state enum
  - GAP/TIMEOUT defaults shared with the engine's timing constants
- One natural sub-module, cycle_timer: a clear/enable counter with a terminal flag. It is instantiated twice, once for the gap and once for the timeout.

Test Plan:
- Bench uses GAP_CYCLES=4 and TIMEOUT_CYCLES=20.
- Normal sweep: start=160, step=3, dir=0, steps=4, engine model answers eng_done 10 cycles after each trigger -> codes 160, 163, 166, 169; 4 trig pulses; step_idx ends at 3; one sweep_done; sat=0; code returns to 128.
- Subtract with saturation: start=5, step=3, dir=1, steps=5 -> trains at 5 and 2, then a clamp to 0 with no third trigger; sat=1; sweep_done=1.
- Timeout: engine never returns eng_done -> fault=1 exactly 20 cycles after the trigger; busy=0; no sweep_done. The next start clears fault.
- Abort: abort asserted during GAP of step 1 -> IDLE next cycle; no further trig; code=128; sweep_done stays 0.
- Zero steps and retrigger: cfg_steps=0 -> sweep_done one cycle after the start edge with no trig. A start held high for 100 cycles launches only one sweep.
- Reset mid-WAIT_DONE -> all outputs at reset values; a spurious eng_done afterwards has no effect.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared constants and state encoding for the pulse-train sweep sequencer.
// Timing defaults match the pulse engine's 50 MHz timing constants.
package pulse_pkg;

    localparam int CODE_W = 8;
    localparam int STEP_W = 6;
    localparam int CNT_W  = 22;

    // DAC code 128 is 0 V; 0 is +5 V and 255 is -5 V.
    localparam logic [CODE_W-1:0] ZERO_CODE = CODE_W'(128);

    localparam int GAP_CYCLES_DEF     = 50_000;
    localparam int TIMEOUT_CYCLES_DEF = 2_000_000;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        TRIG,
        WAIT_DONE,
        GAP,
        STEP
    } state_t;

endpackage

// File: rtl/cycle_timer.sv
// Clear/enable cycle counter with a terminal flag raised when the count
// equals TERM-1; clear has priority over enable.
module cycle_timer #(
    parameter int CNT_W = 22,
    parameter int TERM  = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign terminal = (count_reg == CNT_W'(TERM - 1));

endmodule

// File: rtl/pulse_sweep_sequencer.sv
// Steps the pulse engine's write DAC code through a sweep: load code, trigger
// one train, wait for train completion, idle a gap, then step or finish.
module pulse_sweep_sequencer
    import pulse_pkg::*;
#(
    parameter int GAP_CYCLES     = GAP_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CODE_W-1:0] cfg_start_code,
    input  logic [CODE_W-1:0] cfg_step,
    input  logic              cfg_dir,
    input  logic [STEP_W-1:0] cfg_steps,
    input  logic [2:0]        cfg_mode,
    input  logic              eng_done,
    output logic              eng_trig,
    output logic [CODE_W-1:0] eng_write_code,
    output logic [2:0]        eng_mode_sel,
    output logic [STEP_W-1:0] step_idx,
    output logic              busy,
    output logic              sweep_done,
    output logic              sat,
    output logic              fault
);

    state_t            state_reg, state_next;
    logic              start_q_reg;
    logic [CODE_W-1:0] code_reg, code_next;
    logic [CODE_W-1:0] step_reg;
    logic              dir_reg;
    logic [STEP_W-1:0] steps_reg;
    logic [2:0]        mode_reg;
    logic [STEP_W-1:0] step_idx_reg, step_idx_next;
    logic              sat_reg, sat_next;
    logic              fault_reg, fault_next;
    logic              sweep_done_reg, sweep_done_next;
    logic [CODE_W-1:0] write_code_reg;
    logic [2:0]        mode_sel_reg;

    logic trig, launch;
    logic gap_clear, gap_en, gap_term;
    logic to_clear, to_en, to_term;
    logic last_step;
    logic [CODE_W:0] sum_next;

    cycle_timer #(.CNT_W(CNT_W), .TERM(GAP_CYCLES)) u_gap_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (gap_clear),
        .enable   (gap_en),
        .terminal (gap_term)
    );

    cycle_timer #(.CNT_W(CNT_W), .TERM(TIMEOUT_CYCLES)) u_timeout_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (to_clear),
        .enable   (to_en),
        .terminal (to_term)
    );

    // One extra bit catches both overflow past 255 and borrow below 0.
    assign sum_next  = dir_reg ? ({1'b0, code_reg} - {1'b0, step_reg})
                               : ({1'b0, code_reg} + {1'b0, step_reg});
    assign last_step = (({1'b0, step_idx_reg} + (STEP_W + 1)'(1)) == {1'b0, steps_reg});

    always_comb begin
        state_next      = state_reg;
        code_next       = code_reg;
        step_idx_next   = step_idx_reg;
        sat_next        = sat_reg;
        fault_next      = fault_reg;
        sweep_done_next = 1'b0;
        trig            = 1'b0;
        launch          = 1'b0;
        gap_clear       = 1'b0;
        gap_en          = 1'b0;
        to_clear        = 1'b0;
        to_en           = 1'b0;

        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start && !start_q_reg) begin
                        launch        = 1'b1;
                        code_next     = cfg_start_code;
                        step_idx_next = '0;
                        sat_next      = 1'b0;
                        fault_next    = 1'b0;
                        if (cfg_steps == '0) begin
                            sweep_done_next = 1'b1;
                        end else begin
                            state_next = ARM;
                        end
                    end
                end
                ARM: state_next = TRIG;
                TRIG: begin
                    trig       = 1'b1;
                    to_clear   = 1'b1;
                    state_next = WAIT_DONE;
                end
                WAIT_DONE: begin
                    to_en = 1'b1;
                    if (eng_done) begin
                        gap_clear  = 1'b1;
                        state_next = GAP;
                    end else if (to_term) begin
                        fault_next = 1'b1;
                        state_next = IDLE;
                    end
                end
                GAP: begin
                    gap_en = 1'b1;
                    if (gap_term) begin
                        state_next = STEP;
                    end
                end
                STEP: begin
                    if (last_step) begin
                        sweep_done_next = 1'b1;
                        state_next      = IDLE;
                    end else if (sum_next[CODE_W]) begin
                        code_next       = dir_reg ? '0 : '1;
                        sat_next        = 1'b1;
                        sweep_done_next = 1'b1;
                        state_next      = IDLE;
                    end else begin
                        code_next     = sum_next[CODE_W-1:0];
                        step_idx_next = step_idx_reg + STEP_W'(1);
                        state_next    = ARM;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            start_q_reg    <= 1'b0;
            code_reg       <= ZERO_CODE;
            step_reg       <= '0;
            dir_reg        <= 1'b0;
            steps_reg      <= '0;
            mode_reg       <= '0;
            step_idx_reg   <= '0;
            sat_reg        <= 1'b0;
            fault_reg      <= 1'b0;
            sweep_done_reg <= 1'b0;
            write_code_reg <= ZERO_CODE;
            mode_sel_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            start_q_reg    <= start;
            code_reg       <= code_next;
            step_idx_reg   <= step_idx_next;
            sat_reg        <= sat_next;
            fault_reg      <= fault_next;
            sweep_done_reg <= sweep_done_next;
            if (launch) begin
                step_reg  <= cfg_step;
                dir_reg   <= cfg_dir;
                steps_reg <= cfg_steps;
                mode_reg  <= cfg_mode;
            end
            // Engine inputs follow the next state so the code settles in ARM.
            if (state_next == IDLE) begin
                write_code_reg <= ZERO_CODE;
                mode_sel_reg   <= '0;
            end else begin
                write_code_reg <= code_next;
                mode_sel_reg   <= launch ? cfg_mode : mode_reg;
            end
        end
    end

    assign eng_trig       = trig;
    assign eng_write_code = write_code_reg;
    assign eng_mode_sel   = mode_sel_reg;
    assign step_idx       = step_idx_reg;
    assign busy           = (state_reg != IDLE);
    assign sweep_done     = sweep_done_reg;
    assign sat            = sat_reg;
    assign fault          = fault_reg;

endmodule
